// File: rtl/inst_axi_bridge.sv
// Instruction fetch to AXI4 read bridge: one single-beat read per fetch request,
// in-order return, bounded outstanding reads, and flush-driven response discard.
module inst_axi_bridge #(
  parameter int         MAX_OUTSTANDING = 4,
  parameter logic [3:0] AXI_ID          = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        inst_addr_valid,
  output logic        inst_addr_ready,
  input  logic [31:0] inst_addr,
  output logic        inst_line_valid,
  input  logic        inst_line_ready,
  output logic [31:0] inst_line,
  output logic        inst_line_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          r_ar_pend;
  logic [31:0]   r_araddr;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;

  logic          w_addr_hs;
  logic          w_ar_hs;
  logic          w_r_hs;
  logic          w_dropping;
  logic [CW-1:0] w_out_nxt;
  logic          w_unused;

  assign w_unused = ^{rid, rlast, rresp[0], inst_addr[1:0]};

  assign arid    = AXI_ID;
  assign araddr  = r_araddr;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arvalid = r_ar_pend;

  // The AR slot may refill in the same cycle it drains, giving one issue per cycle.
  assign inst_addr_ready = ~flush & (r_outstanding < MAX_CNT) & (~r_ar_pend | arready);

  assign w_addr_hs = inst_addr_valid & inst_addr_ready;
  assign w_ar_hs   = r_ar_pend & arready;
  assign w_r_hs    = rvalid & rready;

  assign w_dropping      = (r_drop_cnt != '0) | flush;
  assign inst_line       = rdata;
  assign inst_line_err   = rresp[1];
  assign inst_line_valid = rvalid & ~w_dropping;
  assign rready          = w_dropping | inst_line_ready;

  // A stray beat with nothing outstanding leaves the count pinned at zero.
  always_comb begin
    w_out_nxt = r_outstanding;
    if (w_addr_hs && !w_r_hs)
      w_out_nxt = r_outstanding + CNT_ONE;
    else if (!w_addr_hs && w_r_hs && (r_outstanding != '0))
      w_out_nxt = r_outstanding - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ar_pend <= 1'b0;
      r_araddr  <= 32'd0;
    end else if (w_addr_hs) begin
      r_ar_pend <= 1'b1;
      r_araddr  <= {inst_addr[31:2], 2'b00};
    end else if (w_ar_hs) begin
      r_ar_pend <= 1'b0;
    end
  end

  // Flush reloads from the post-update count so a still-queued AR is dropped too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_out_nxt;
      if (flush)
        r_drop_cnt <= w_out_nxt;
      else if (w_r_hs && (r_drop_cnt != '0))
        r_drop_cnt <= r_drop_cnt - CNT_ONE;
    end
  end
endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed bench for inst_axi_bridge: per-cycle vector table plus multi-cycle sequences
// driven through a small in-order AXI read slave.
module tb_inst_axi_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        inst_addr_valid;
  logic        inst_addr_ready;
  logic [31:0] inst_addr;
  logic        inst_line_valid;
  logic        inst_line_ready;
  logic [31:0] inst_line;
  logic        inst_line_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  inst_axi_bridge #(.MAX_OUTSTANDING(4), .AXI_ID(4'd0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inst_addr_valid(inst_addr_valid), .inst_addr_ready(inst_addr_ready), .inst_addr(inst_addr),
    .inst_line_valid(inst_line_valid), .inst_line_ready(inst_line_ready),
    .inst_line(inst_line), .inst_line_err(inst_line_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // ---------------- slave model and per-cycle engine ----------------
  typedef struct { logic [31:0] data; int due; } beat_t;
  beat_t       q[$];
  logic [31:0] dq[$];
  bit          slave_en = 0;
  int          lat = 2, rel_budget = 1000, cycnt = 0;
  int          n_acc, n_ar, n_rhs, n_dlv, ar_first, ar_last, d_first, d_last;
  logic        last_aready, last_arvalid;

  task automatic clr();
    n_acc = 0; n_ar = 0; n_rhs = 0; n_dlv = 0;
    ar_first = 0; ar_last = 0; d_first = 0; d_last = 0;
    dq.delete();
  endtask

  // Called at posedge+1: drives R, samples mid-cycle, advances to next posedge+1.
  task automatic cyc();
    if (slave_en) begin
      if (q.size() > 0 && q[0].due <= cycnt && rel_budget > 0) begin
        rvalid = 1'b1; rdata = q[0].data; rresp = 2'b00;
      end else begin
        rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
      end
    end
    #4;
    last_aready  = inst_addr_ready;
    last_arvalid = arvalid;
    if (inst_addr_valid && inst_addr_ready) n_acc++;
    if (rvalid && rready) begin
      n_rhs++;
      if (slave_en && q.size() > 0) begin q.delete(0); rel_budget--; end
    end
    if (arvalid && arready) begin
      q.push_back('{data: mem(araddr), due: cycnt + lat});
      if (n_ar == 0) ar_first = cycnt;
      ar_last = cycnt;
      n_ar++;
    end
    if (inst_line_valid && inst_line_ready) begin
      dq.push_back(inst_line);
      if (n_dlv == 0) d_first = cycnt;
      d_last = cycnt;
      n_dlv++;
    end
    @(posedge clk); #1;
    cycnt++;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic fl; logic av; logic [31:0] ad; logic arr; logic rv; logic [31:0] rd; logic [1:0] rr; logic ilr;
    logic e_ardy; logic e_arv; logic [31:0] e_araddr; logic e_lv; logic [31:0] e_line; logic e_err; logic e_rrdy;
  } vec_t;
  vec_t vt[13];

  initial begin
    rst = 1'b0; flush = 0; inst_addr_valid = 0; inst_addr = 0; inst_line_ready = 1;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    clr();
    @(posedge clk); #1;
    #3;
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_addr_ready", {31'd0, inst_addr_ready}, 32'd1);
    chk("rst_outstanding", 32'(dut.r_outstanding), 32'd0);
    chk("rst_drop_cnt", 32'(dut.r_drop_cnt), 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd1);
    chk("ar_const", {arid, arlen, arsize, arburst}, {4'd0, 8'd0, 3'b010, 2'b01});
    @(posedge clk); #1;
    rst = 1'b1;

    //          fl av addr          arr rv rdata          rr    ilr  ardy arv araddr        lv line           err rrdy
    vt[0]  = '{0, 0, 32'h0,        0, 0, 32'h0,         2'b00, 1,  1, 0, 32'h0,        0, 32'h0,         0, 1};
    vt[1]  = '{0, 0, 32'h0,        0, 0, 32'h0,         2'b00, 0,  1, 0, 32'h0,        0, 32'h0,         0, 0};
    vt[2]  = '{0, 1, 32'hBFC00004, 1, 0, 32'h0,         2'b00, 1,  1, 0, 32'h0,        0, 32'h0,         0, 1};
    vt[3]  = '{0, 0, 32'h0,        1, 0, 32'h0,         2'b00, 1,  1, 1, 32'hBFC00004, 0, 32'h0,         0, 1};
    vt[4]  = '{0, 0, 32'h0,        1, 0, 32'h0,         2'b00, 1,  1, 0, 32'hBFC00004, 0, 32'h0,         0, 1};
    vt[5]  = '{0, 0, 32'h0,        1, 1, 32'h24080001,  2'b00, 1,  1, 0, 32'hBFC00004, 1, 32'h24080001,  0, 1};
    vt[6]  = '{0, 0, 32'h0,        1, 0, 32'h0,         2'b00, 1,  1, 0, 32'hBFC00004, 0, 32'h0,         0, 1};
    vt[7]  = '{0, 1, 32'h00000123, 0, 0, 32'h0,         2'b00, 1,  1, 0, 32'hBFC00004, 0, 32'h0,         0, 1};
    vt[8]  = '{0, 0, 32'h0,        0, 0, 32'h0,         2'b00, 1,  0, 1, 32'h00000120, 0, 32'h0,         0, 1};
    vt[9]  = '{0, 0, 32'h0,        1, 0, 32'h0,         2'b00, 1,  1, 1, 32'h00000120, 0, 32'h0,         0, 1};
    vt[10] = '{0, 0, 32'h0,        1, 1, 32'hDEADBEEF,  2'b10, 0,  1, 0, 32'h00000120, 1, 32'hDEADBEEF,  1, 0};
    vt[11] = '{0, 0, 32'h0,        1, 1, 32'hDEADBEEF,  2'b10, 1,  1, 0, 32'h00000120, 1, 32'hDEADBEEF,  1, 1};
    vt[12] = '{0, 0, 32'h0,        1, 0, 32'h0,         2'b00, 1,  1, 0, 32'h00000120, 0, 32'h0,         0, 1};

    for (int i = 0; i < 13; i++) begin
      flush = vt[i].fl; inst_addr_valid = vt[i].av; inst_addr = vt[i].ad; arready = vt[i].arr;
      rvalid = vt[i].rv; rdata = vt[i].rd; rresp = vt[i].rr; inst_line_ready = vt[i].ilr;
      #4;
      chk($sformatf("v%0d_addr_ready", i), {31'd0, inst_addr_ready}, {31'd0, vt[i].e_ardy});
      chk($sformatf("v%0d_arvalid", i), {31'd0, arvalid}, {31'd0, vt[i].e_arv});
      chk($sformatf("v%0d_araddr", i), araddr, vt[i].e_araddr);
      chk($sformatf("v%0d_line_valid", i), {31'd0, inst_line_valid}, {31'd0, vt[i].e_lv});
      if (vt[i].e_lv) begin
        chk($sformatf("v%0d_line", i), inst_line, vt[i].e_line);
        chk($sformatf("v%0d_err", i), {31'd0, inst_line_err}, {31'd0, vt[i].e_err});
      end
      chk($sformatf("v%0d_rready", i), {31'd0, rready}, {31'd0, vt[i].e_rrdy});
      @(posedge clk); #1;
    end
    chk("single_outstanding_zero", 32'(dut.r_outstanding), 32'd0);

    // ---------------- streaming ----------------
    slave_en = 1; lat = 2; rel_budget = 1000; arready = 1; inst_line_ready = 1; clr();
    for (int k = 0; k < 40 && n_dlv < 8; k++) begin
      inst_addr_valid = (n_acc < 8);
      inst_addr = 32'h1000 + 32'(4 * n_acc);
      cyc();
    end
    inst_addr_valid = 0;
    chk("stream_ar_count", n_ar, 8);
    chk("stream_ar_back_to_back", ar_last - ar_first, 7);
    chk("stream_dlv_count", n_dlv, 8);
    chk("stream_dlv_no_gaps", d_last - d_first, 7);
    for (int k = 0; k < 8 && k < dq.size(); k++)
      chk($sformatf("stream_data%0d", k), dq[k], mem(32'h1000 + 32'(4 * k)));
    cyc();
    chk("stream_outstanding_zero", 32'(dut.r_outstanding), 32'd0);

    // ---------------- credit limit ----------------
    clr(); rel_budget = 0; arready = 1;
    for (int k = 0; k < 8; k++) begin
      inst_addr_valid = 1; inst_addr = 32'h3000 + 32'(4 * n_acc);
      cyc();
    end
    chk("credit_acc", n_acc, 4);
    chk("credit_ar", n_ar, 4);
    chk("credit_ready_low", {31'd0, last_aready}, 32'd0);
    rel_budget = 1;
    cyc();
    chk("credit_beat_back", n_rhs, 1);
    chk("credit_ready_low_on_beat", {31'd0, last_aready}, 32'd0);
    cyc();
    chk("credit_ready_reopen", {31'd0, last_aready}, 32'd1);
    chk("credit_one_more", n_acc, 5);
    inst_addr_valid = 0; rel_budget = 1000;
    for (int k = 0; k < 30 && n_rhs < 5; k++) cyc();
    chk("credit_drain", n_dlv, 5);
    if (dq.size() == 5) chk("credit_last_data", dq[4], mem(32'h3010));

    // ---------------- flush ----------------
    clr(); rel_budget = 0; arready = 1; inst_line_ready = 1;
    for (int k = 0; k < 3; k++) begin
      inst_addr_valid = 1; inst_addr = 32'h6000 + 32'(4 * k);
      cyc();
    end
    inst_addr_valid = 0; cyc();
    chk("flush_inflight", n_ar, 3);
    flush = 1; inst_addr_valid = 1; inst_addr = 32'h2000; cyc();
    flush = 0; inst_addr_valid = 0;
    chk("flush_blocks_req", n_acc, 3);
    chk("flush_drop_cnt", 32'(dut.r_drop_cnt), 32'd3);
    inst_line_ready = 0; rel_budget = 1000;
    for (int k = 0; k < 20 && n_rhs < 3; k++) cyc();
    chk("flush_beats_consumed", n_rhs, 3);
    chk("flush_none_delivered", n_dlv, 0);
    inst_line_ready = 1; inst_addr_valid = 1; inst_addr = 32'h2000; cyc();
    inst_addr_valid = 0;
    for (int k = 0; k < 20 && n_dlv < 1; k++) cyc();
    chk("flush_next_count", n_dlv, 1);
    if (dq.size() > 0) chk("flush_next_data", dq[0], mem(32'h2000));

    // ---------------- flush with blocked AR ----------------
    clr(); arready = 0; lat = 1;
    inst_addr_valid = 1; inst_addr = 32'h4000; cyc();
    inst_addr_valid = 0; flush = 1; cyc();
    flush = 0;
    chk("blk_arvalid_in_flush", {31'd0, last_arvalid}, 32'd1);
    chk("blk_drop_cnt", 32'(dut.r_drop_cnt), 32'd1);
    arready = 1;
    for (int k = 0; k < 20 && n_rhs < 1; k++) cyc();
    chk("blk_ar_issued", n_ar, 1);
    chk("blk_beat_consumed", n_rhs, 1);
    chk("blk_none_delivered", n_dlv, 0);
    chk("blk_outstanding", 32'(dut.r_outstanding), 32'd0);
    chk("blk_drop_zero", 32'(dut.r_drop_cnt), 32'd0);

    // ---------------- async reset mid-burst ----------------
    clr(); rel_budget = 0; arready = 1; lat = 2;
    for (int k = 0; k < 2; k++) begin
      inst_addr_valid = 1; inst_addr = 32'h5000 + 32'(4 * k);
      cyc();
    end
    inst_addr_valid = 0; arready = 0;
    #2;
    chk("ares_pre_arvalid", {31'd0, arvalid}, 32'd1);
    chk("ares_pre_outstanding", 32'(dut.r_outstanding), 32'd2);
    rst = 0;
    #1;
    chk("ares_arvalid", {31'd0, arvalid}, 32'd0);
    chk("ares_outstanding", 32'(dut.r_outstanding), 32'd0);
    chk("ares_araddr", araddr, 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
